// File: rtl/axis_pkg.sv
// Shared constants and tkeep helpers for the AXI4-Stream ingress datapath.
// Helpers take tkeep zero-extended to KEEP_MAX_W lanes (up to 1024-bit data).
package axis_pkg;

    localparam int unsigned FRAME_BYTES_W = 16;
    localparam int unsigned FRAME_CNT_W   = 32;
    localparam int unsigned KEEP_MAX_W    = 128;

    // Number of enabled byte lanes.
    function automatic logic [FRAME_BYTES_W-1:0] keep_popcount(input logic [KEEP_MAX_W-1:0] keep);
        logic [FRAME_BYTES_W-1:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < KEEP_MAX_W; i++) begin
            cnt = cnt + FRAME_BYTES_W'(keep[i]);
        end
        return cnt;
    endfunction

    // All of the low 'width' lanes are enabled.
    function automatic logic keep_is_full(input logic [KEEP_MAX_W-1:0] keep, input int unsigned width);
        logic full;
        full = 1'b1;
        for (int unsigned i = 0; i < KEEP_MAX_W; i++) begin
            if (i < width && !keep[i]) begin
                full = 1'b0;
            end
        end
        return full;
    endfunction

    // Nonzero and contiguous from lane 0 (2^k-1); upper lanes must be zero.
    function automatic logic keep_is_contig(input logic [KEEP_MAX_W-1:0] keep);
        return (keep != '0) && ((keep & (keep + KEEP_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous FIFO with registered write-ready and combinational head read.
// Ports: wr_* push side (wr_ready_o registered), rd_* pop side
// (rd_data_o is the head entry, rd_valid_o = fill_o != 0), fill_o occupancy.
module axis_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned FILL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    output logic [WIDTH-1:0]  rd_data_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [FILL_W-1:0] fill_o
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              ready_q, ready_d;
    logic              push, pop;

    assign push = wr_valid_i && ready_q;
    assign pop  = rd_ready_i && (fill_q != '0);

    // Next pointers, occupancy and ready.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({push, pop})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
        ready_d = (fill_d < FILL_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            ready_q  <= ready_d;
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o  = mem_q[rd_ptr_q];
    assign rd_valid_o = (fill_q != '0);
    assign wr_ready_o = ready_q;
    assign fill_o     = fill_q;

endmodule

// File: rtl/axis_ingress_buf.sv
// AXI4-Stream ingress buffer: FIFO-buffers beats tagged with start-of-frame,
// counts bytes per frame, counts frames and flags illegal tkeep.
// Ports: s_axis_* ingress slave (tready registered), axis_* internal stream
// driven from the FIFO head, beat_accept ingress handshake, fill occupancy,
// frame_done/frame_bytes/frame_count frame statistics, keep_err pulse.
module axis_ingress_buf
    import axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 8,
    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    localparam int unsigned FILL_W     = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    output logic [DATA_WIDTH-1:0]    axis_tdata,
    output logic [KEEP_WIDTH-1:0]    axis_tkeep,
    output logic                     axis_tvalid,
    input  logic                     axis_tready,
    output logic                     axis_tlast,
    output logic                     axis_tsof,
    output logic                     beat_accept,
    output logic [FILL_W-1:0]        fill,
    output logic                     frame_done,
    output logic [FRAME_BYTES_W-1:0] frame_bytes,
    output logic [FRAME_CNT_W-1:0]   frame_count,
    output logic                     keep_err
);

    localparam int unsigned ENTRY_W = DATA_WIDTH + KEEP_WIDTH + 2;

    logic [ENTRY_W-1:0] wr_entry, rd_entry;

    logic                     in_frame_q, in_frame_d;
    logic [FRAME_BYTES_W-1:0] acc_q, acc_d;
    logic                     last_seen_q, last_seen_d;
    logic [FRAME_BYTES_W-1:0] last_sum_q, last_sum_d;
    logic                     err_seen_q, err_seen_d;
    logic                     frame_done_q, frame_done_d;
    logic [FRAME_BYTES_W-1:0] frame_bytes_q, frame_bytes_d;
    logic [FRAME_CNT_W-1:0]   frame_count_q, frame_count_d;
    logic                     keep_err_q, keep_err_d;

    logic [FRAME_BYTES_W:0]   sum_wide;
    logic [FRAME_BYTES_W-1:0] sum_sat;
    logic                     keep_bad;

    assign beat_accept = s_axis_tvalid && s_axis_tready;
    assign wr_entry    = {!in_frame_q, s_axis_tlast, s_axis_tkeep, s_axis_tdata};

    axis_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_data_i  (wr_entry),
        .wr_valid_i (s_axis_tvalid),
        .wr_ready_o (s_axis_tready),
        .rd_data_o  (rd_entry),
        .rd_valid_o (axis_tvalid),
        .rd_ready_i (axis_tready),
        .fill_o     (fill)
    );

    assign axis_tdata = rd_entry[DATA_WIDTH-1:0];
    assign axis_tkeep = rd_entry[DATA_WIDTH +: KEEP_WIDTH];
    assign axis_tlast = rd_entry[DATA_WIDTH + KEEP_WIDTH];
    assign axis_tsof  = rd_entry[ENTRY_W-1];

    // Saturating running byte sum including the current beat.
    always_comb begin
        sum_wide = {1'b0, acc_q} + {1'b0, keep_popcount(KEEP_MAX_W'(s_axis_tkeep))};
        sum_sat  = sum_wide[FRAME_BYTES_W] ? '1 : sum_wide[FRAME_BYTES_W-1:0];
        keep_bad = s_axis_tlast ? !keep_is_contig(KEEP_MAX_W'(s_axis_tkeep))
                                : !keep_is_full(KEEP_MAX_W'(s_axis_tkeep), KEEP_WIDTH);
    end

    // Frame tracking; statistics are staged once so they publish one edge
    // after the accepting edge.
    always_comb begin
        in_frame_d    = in_frame_q;
        acc_d         = acc_q;
        last_seen_d   = beat_accept && s_axis_tlast;
        last_sum_d    = last_sum_q;
        err_seen_d    = beat_accept && keep_bad;
        frame_done_d  = last_seen_q;
        frame_bytes_d = frame_bytes_q;
        frame_count_d = frame_count_q;
        keep_err_d    = err_seen_q;
        if (beat_accept) begin
            in_frame_d = !s_axis_tlast;
            if (s_axis_tlast) begin
                acc_d      = '0;
                last_sum_d = sum_sat;
            end else begin
                acc_d = sum_sat;
            end
        end
        if (last_seen_q) begin
            frame_bytes_d = last_sum_q;
            frame_count_d = frame_count_q + FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_frame_q    <= 1'b0;
            acc_q         <= '0;
            last_seen_q   <= 1'b0;
            last_sum_q    <= '0;
            err_seen_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_bytes_q <= '0;
            frame_count_q <= '0;
            keep_err_q    <= 1'b0;
        end else begin
            in_frame_q    <= in_frame_d;
            acc_q         <= acc_d;
            last_seen_q   <= last_seen_d;
            last_sum_q    <= last_sum_d;
            err_seen_q    <= err_seen_d;
            frame_done_q  <= frame_done_d;
            frame_bytes_q <= frame_bytes_d;
            frame_count_q <= frame_count_d;
            keep_err_q    <= keep_err_d;
        end
    end

    assign frame_done  = frame_done_q;
    assign frame_bytes = frame_bytes_q;
    assign frame_count = frame_count_q;
    assign keep_err    = keep_err_q;

endmodule

// File: tb/tb_axis_ingress_buf.sv
// Directed bench for axis_ingress_buf: cycle table plus multi-cycle sequences,
// with a negedge scoreboard checking every popped beat.
module tb_axis_ingress_buf;

    localparam int unsigned DW = 64;
    localparam int unsigned KW = 8;
    localparam int unsigned FW = 4;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] axis_tdata;
    logic [KW-1:0] axis_tkeep;
    logic          axis_tvalid;
    logic          axis_tready;
    logic          axis_tlast;
    logic          axis_tsof;
    logic          beat_accept;
    logic [FW-1:0] fill;
    logic          frame_done;
    logic [15:0]   frame_bytes;
    logic [31:0]   frame_count;
    logic          keep_err;

    axis_ingress_buf #(.DATA_WIDTH(DW), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .axis_tdata(axis_tdata), .axis_tkeep(axis_tkeep),
        .axis_tvalid(axis_tvalid), .axis_tready(axis_tready),
        .axis_tlast(axis_tlast), .axis_tsof(axis_tsof),
        .beat_accept(beat_accept), .fill(fill),
        .frame_done(frame_done), .frame_bytes(frame_bytes),
        .frame_count(frame_count), .keep_err(keep_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected beats, built from the bench's own frame model.
    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          sof;
    } beat_t;

    beat_t       sb[$];
    logic        mdl_in_frame = 1'b0;
    int          sof_seen     = 0;
    int          done_seen    = 0;
    int          err_seen     = 0;
    int          max_fill     = 0;
    logic        exp_bytes_en = 1'b0;
    logic [15:0] exp_bytes    = '0;
    logic        rand_rdy_en  = 1'b0;

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                mdl_in_frame = 1'b0;
            end else begin
                if (axis_tvalid && axis_tready) begin
                    if (sb.size() == 0) begin
                        check("pop_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("pop_data", axis_tdata, e.data);
                        check("pop_keep", 64'(axis_tkeep), 64'(e.keep));
                        check("pop_last_sof", 64'({axis_tlast, axis_tsof}), 64'({e.last, e.sof}));
                    end
                    if (axis_tsof) sof_seen++;
                end
                if (s_axis_tvalid && s_axis_tready) begin
                    e = '{data: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast, sof: !mdl_in_frame};
                    sb.push_back(e);
                    mdl_in_frame = !s_axis_tlast;
                end
                if (frame_done) begin
                    done_seen++;
                    if (exp_bytes_en) check("done_bytes", 64'(frame_bytes), 64'(exp_bytes));
                end
                if (keep_err) err_seen++;
                if (int'(fill) > max_fill) max_fill = int'(fill);
            end
        end
    end

    // Random downstream stall for the stress phase.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_rdy_en) axis_tready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Hold a beat until accepted, bounded.
    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        logic acc;
        acc = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && sb.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          vld;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          mrdy;
        logic [FW-1:0] e_fill;
        logic          e_srdy;
        logic          e_vld;
        logic [DW-1:0] e_data;
        logic [KW-1:0] e_keep;
        logic          e_sof;
        logic          e_last;
        logic          e_done;
        logic [15:0]   e_bytes;
        logic [31:0]   e_cnt;
        logic          e_err;
    } vec_t;

    vec_t vt[9];

    initial begin
        int d0, c0, s0, e0, nfr, nbeat;
        logic [63:0] a1, b1, b2, b3;
        a1 = 64'h1111_2222_3333_4444;
        b1 = 64'hB1B1_0000_0000_0001;
        b2 = 64'hB2B2_0000_0000_0002;
        b3 = 64'hB3B3_0000_0000_0003;
        //        vld data keep   last mrdy fill srdy vld edata  ekeep  sof  last done bytes   cnt err
        vt[0] = '{0, 0,   8'h00, 0, 1, 4'd0, 1, 0, 0,  8'h00, 0, 0, 0, 16'd0,  32'd0, 0};
        vt[1] = '{1, a1,  8'h0F, 1, 1, 4'd1, 1, 1, a1, 8'h0F, 1, 1, 0, 16'd0,  32'd0, 0};
        vt[2] = '{0, 0,   8'h00, 0, 1, 4'd0, 1, 0, 0,  8'h00, 0, 0, 1, 16'd4,  32'd1, 0};
        vt[3] = '{0, 0,   8'h00, 0, 1, 4'd0, 1, 0, 0,  8'h00, 0, 0, 0, 16'd4,  32'd1, 0};
        vt[4] = '{1, b1,  8'hF0, 0, 0, 4'd1, 1, 1, b1, 8'hF0, 1, 0, 0, 16'd4,  32'd1, 0};
        vt[5] = '{1, b2,  8'hFF, 0, 0, 4'd2, 1, 1, b1, 8'hF0, 1, 0, 0, 16'd4,  32'd1, 1};
        vt[6] = '{1, b3,  8'h05, 1, 1, 4'd2, 1, 1, b2, 8'hFF, 0, 0, 0, 16'd4,  32'd1, 0};
        vt[7] = '{0, 0,   8'h00, 0, 1, 4'd1, 1, 1, b3, 8'h05, 0, 1, 1, 16'd14, 32'd2, 1};
        vt[8] = '{0, 0,   8'h00, 0, 1, 4'd0, 1, 0, 0,  8'h00, 0, 0, 0, 16'd14, 32'd2, 0};

        rst_n = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        axis_tready = 1'b0;
        #12;
        check("rst_fill", 64'(fill), 64'd0);
        check("rst_srdy", 64'(s_axis_tready), 64'd0);
        check("rst_vld", 64'(axis_tvalid), 64'd0);
        check("rst_stats", 64'({frame_done, keep_err, frame_bytes, frame_count}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("srdy_before_edge", 64'(s_axis_tready), 64'd0);

        // Cycle table: single-beat frame, then a frame with two illegal tkeeps.
        for (int i = 0; i < 9; i++) begin
            s_axis_tvalid = vt[i].vld;
            s_axis_tdata  = vt[i].data;
            s_axis_tkeep  = vt[i].keep;
            s_axis_tlast  = vt[i].last;
            axis_tready   = vt[i].mrdy;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_fill", i), 64'(fill), 64'(vt[i].e_fill));
            check($sformatf("v%0d_srdy", i), 64'(s_axis_tready), 64'(vt[i].e_srdy));
            check($sformatf("v%0d_vld", i), 64'(axis_tvalid), 64'(vt[i].e_vld));
            check($sformatf("v%0d_done", i), 64'(frame_done), 64'(vt[i].e_done));
            check($sformatf("v%0d_bytes", i), 64'(frame_bytes), 64'(vt[i].e_bytes));
            check($sformatf("v%0d_cnt", i), 64'(frame_count), 64'(vt[i].e_cnt));
            check($sformatf("v%0d_err", i), 64'(keep_err), 64'(vt[i].e_err));
            if (vt[i].e_vld) begin
                check($sformatf("v%0d_data", i), axis_tdata, vt[i].e_data);
                check($sformatf("v%0d_keep", i), 64'(axis_tkeep), 64'(vt[i].e_keep));
                check($sformatf("v%0d_sof_last", i), 64'({axis_tsof, axis_tlast}),
                      64'({vt[i].e_sof, vt[i].e_last}));
            end
        end
        s_axis_tvalid = 1'b0;

        // Backpressure: fill to DEPTH, hold, then release with one bubble.
        axis_tready = 1'b0;
        s0 = sof_seen; d0 = done_seen;
        for (int b = 0; b < 8; b++) begin
            send_beat(64'hC000 + 64'(b), 8'hFF, 1'b0);
            check($sformatf("bp_fill%0d", b), 64'(fill), 64'(b + 1));
        end
        check("bp_srdy_full", 64'(s_axis_tready), 64'd0);
        s_axis_tvalid = 1'b1; s_axis_tdata = 64'hC008; s_axis_tkeep = 8'hFF; s_axis_tlast = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_no_accept", 64'(beat_accept), 64'd0);
            @(posedge clk);
            #1;
            check("bp_fill_hold", 64'(fill), 64'd8);
        end
        axis_tready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_bubble_fill", 64'(fill), 64'd7);
        check("bp_bubble_srdy", 64'(s_axis_tready), 64'd1);
        send_beat(64'hC008, 8'hFF, 1'b0);
        send_beat(64'hC009, 8'hFF, 1'b1);
        drain(100);
        check("bp_one_sof", 64'(sof_seen - s0), 64'd1);
        check("bp_done", 64'(done_seen - d0), 64'd1);
        check("bp_bytes", 64'(frame_bytes), 64'd80);
        check("bp_cnt", 64'(frame_count), 64'd3);

        // Streaming: three back-to-back 3-beat frames, both sides ready.
        max_fill = 0; d0 = done_seen;
        exp_bytes = 16'd19; exp_bytes_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            send_beat(64'hD000 + 64'(f * 3),     8'hFF, 1'b0);
            send_beat(64'hD000 + 64'(f * 3 + 1), 8'hFF, 1'b0);
            send_beat(64'hD000 + 64'(f * 3 + 2), 8'h07, 1'b1);
        end
        drain(50);
        exp_bytes_en = 1'b0;
        check("st_max_fill", 64'(max_fill), 64'd1);
        check("st_done", 64'(done_seen - d0), 64'd3);
        check("st_cnt", 64'(frame_count), 64'd6);

        // Reset mid-frame with two beats buffered.
        axis_tready = 1'b0;
        send_beat(64'hE000, 8'hFF, 1'b0);
        send_beat(64'hE001, 8'hFF, 1'b0);
        check("mr_fill2", 64'(fill), 64'd2);
        rst_n = 1'b0;
        #1;
        check("mr_fill", 64'(fill), 64'd0);
        check("mr_vld", 64'(axis_tvalid), 64'd0);
        check("mr_srdy", 64'(s_axis_tready), 64'd0);
        check("mr_stats", 64'({frame_done, keep_err, frame_bytes, frame_count}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mr_srdy_up", 64'(s_axis_tready), 64'd1);
        axis_tready = 1'b1;
        s0 = sof_seen;
        send_beat(64'hE100, 8'hFF, 1'b0);
        send_beat(64'hE101, 8'h03, 1'b1);
        drain(50);
        check("mr_sof", 64'(sof_seen - s0), 64'd1);
        check("mr_bytes", 64'(frame_bytes), 64'd10);
        check("mr_cnt", 64'(frame_count), 64'd1);

        // Saturation: 9000 full beats in one frame.
        e0 = err_seen; d0 = done_seen;
        exp_bytes = 16'hFFFF; exp_bytes_en = 1'b1;
        for (int b = 0; b < 9000; b++) begin
            send_beat(64'(b), 8'hFF, (b == 8999));
        end
        drain(50);
        exp_bytes_en = 1'b0;
        check("sat_bytes", 64'(frame_bytes), 64'hFFFF);
        check("sat_done", 64'(done_seen - d0), 64'd1);
        check("sat_cnt", 64'(frame_count), 64'd2);
        check("sat_no_err", 64'(err_seen - e0), 64'd0);

        // Random stress: random idles, frame lengths and downstream stalls.
        e0 = err_seen; d0 = done_seen; s0 = sof_seen;
        rand_rdy_en = 1'b1;
        nfr = 0;
        for (int f = 0; f < 80; f++) begin
            nbeat = $urandom_range(1, 5);
            for (int b = 0; b < nbeat; b++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                if (b == nbeat - 1) begin
                    send_beat({$urandom, $urandom}, 8'((16'd1 << $urandom_range(1, 8)) - 16'd1), 1'b1);
                end else begin
                    send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
                end
            end
            nfr++;
        end
        drain(2000);
        rand_rdy_en = 1'b0;
        axis_tready = 1'b1;
        check("rs_done", 64'(done_seen - d0), 64'(nfr));
        check("rs_sof", 64'(sof_seen - s0), 64'(nfr));
        check("rs_cnt", 64'(frame_count), 64'(2 + nfr));
        check("rs_no_err", 64'(err_seen - e0), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
